// File: rtl/decode_pkg.sv
// decode_pkg: opcode and format constants, decoded-field struct and the shared decode function.
package decode_pkg;
  localparam logic [4:0] OP_SDT = 5'h10;
  localparam logic [4:0] OP_BRANCH = 5'h11;
  localparam logic [4:0] OP_INVALID = 5'h1F;
  localparam logic [1:0] FMT_DP = 2'b00;
  localparam logic [1:0] FMT_SDT = 2'b01;
  localparam logic [2:0] FMT_BRANCH = 3'b101;
  typedef struct packed {
    logic [3:0]  cond;
    logic [4:0]  opcode;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        immediate_operand;
    logic        cpsr_write;
    logic [1:0]  shift_type;
    logic [4:0]  rm_shift;
    logic [3:0]  rotate_val;
    logic [7:0]  immediate_val;
    logic        pre_post;
    logic        up_down;
    logic        byte_word;
    logic        write_back;
    logic        load_store;
    logic [11:0] immediate_offset;
    logic [7:0]  rm_shift_sdt;
    logic        link_bit;
    logic [23:0] branch_imm;
  } dec_fields_t;
  function automatic dec_fields_t decode(logic [31:0] i);
    dec_fields_t d;
    d = '0;
    d.cond = i[31:28];
    d.opcode = OP_INVALID;
    if (i[27:26] == FMT_DP) begin
      d.opcode = {1'b0, i[24:21]};
      d.rn = i[19:16];
      d.rd = i[15:12];
      d.rm = i[3:0];
      d.immediate_operand = i[25];
      d.cpsr_write = i[20];
      d.shift_type = i[6:5];
      d.rm_shift = i[11:7];
      d.rotate_val = i[11:8];
      d.immediate_val = i[7:0];
    end else if (i[27:26] == FMT_SDT) begin
      d.opcode = OP_SDT;
      d.rn = i[19:16];
      d.rd = i[15:12];
      d.rm = i[3:0];
      d.immediate_operand = i[25];
      {d.pre_post, d.up_down, d.byte_word, d.write_back, d.load_store} = i[24:20];
      d.immediate_offset = i[11:0];
      d.rm_shift_sdt = i[11:4];
    end else if (i[27:25] == FMT_BRANCH) begin
      d.opcode = OP_BRANCH;
      d.link_bit = i[24];
      d.branch_imm = i[23:0];
    end
    return d;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH-entry circular buffer with occupancy count and full/empty flags.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: buffered decode stage; FIFO plus one output register, with direct bypass when the FIFO is empty.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [31:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic dec_valid,
  input  logic dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [3:0] cond,
  output logic [4:0] opcode,
  output logic [3:0] rn,
  output logic [3:0] rd,
  output logic [3:0] rm,
  output logic immediate_operand,
  output logic cpsr_write,
  output logic [1:0] shift_type,
  output logic [4:0] rm_shift,
  output logic [3:0] rotate_val,
  output logic [7:0] immediate_val,
  output logic pre_post,
  output logic up_down,
  output logic byte_word,
  output logic write_back,
  output logic load_store,
  output logic [11:0] immediate_offset,
  output logic [7:0] rm_shift_sdt,
  output logic link_bit,
  output logic [23:0] branch_imm,
  output logic [ADDR_W-1:0] branch_target,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int W = 32 + ADDR_W;
  logic clr, full, empty, accept, load, take, pop, push;
  logic [W-1:0] head;
  logic [31:0] src_instr;
  logic [ADDR_W-1:0] src_pc, src_target;
  dec_fields_t src_dec, q;
  assign clr = !reset || flush;
  assign in_ready = !full;
  assign accept = in_valid && !full && !flush;
  assign load = !dec_valid || dec_ready;
  assign pop = load && !empty;
  assign push = accept && !(load && empty);
  assign take = load && (!empty || accept);
  assign {src_pc, src_instr} = empty ? {in_pc, in_instr} : head;
  assign src_dec = decode(src_instr);
  assign src_target = src_pc + ADDR_W'(8) + (ADDR_W'($signed(src_instr[23:0])) << 2);
  instr_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .clr(clr), .push(push), .pop(pop), .wdata({in_pc, in_instr}),
    .rdata(head), .full(full), .empty(empty), .count(occupancy)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      dec_valid <= 1'b0;
      q <= '0;
      q.opcode <= OP_INVALID;
      dec_pc <= '0;
      branch_target <= '0;
    end else if (load) begin
      dec_valid <= take;
      if (take) begin
        q <= src_dec;
        dec_pc <= src_pc;
        branch_target <= src_dec.opcode == OP_BRANCH ? src_target : '0;
      end
    end
  end
  assign cond = q.cond;
  assign opcode = q.opcode;
  assign rn = q.rn;
  assign rd = q.rd;
  assign rm = q.rm;
  assign immediate_operand = q.immediate_operand;
  assign cpsr_write = q.cpsr_write;
  assign shift_type = q.shift_type;
  assign rm_shift = q.rm_shift;
  assign rotate_val = q.rotate_val;
  assign immediate_val = q.immediate_val;
  assign pre_post = q.pre_post;
  assign up_down = q.up_down;
  assign byte_word = q.byte_word;
  assign write_back = q.write_back;
  assign load_store = q.load_store;
  assign immediate_offset = q.immediate_offset;
  assign rm_shift_sdt = q.rm_shift_sdt;
  assign link_bit = q.link_bit;
  assign branch_imm = q.branch_imm;
endmodule
